// File: rtl/mem_traffic_pkg.sv
// Shared types and constants for the memory traffic generator.
package mem_traffic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_e;

    localparam logic [7:0] DEFAULT_SEED = 8'hA5;
    localparam int         ERR_CNT_W    = 8;

endpackage

// File: rtl/mem_traffic_gen.sv
// Write-then-read-back traffic generator for a single-port, registered-read memory.
// Optional first-mismatch capture ports are built when MEM_TRAFFIC_GEN_ERR_CAPTURE_EN is defined.
module mem_traffic_gen
    import mem_traffic_pkg::*;
#(
    parameter int                 ADDR_W = 4,
    parameter int                 DATA_W = 8,
    parameter logic [DATA_W-1:0]  SEED   = DATA_W'(DEFAULT_SEED)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 we_o,
    output logic [ADDR_W-1:0]    addr_o,
    output logic [DATA_W-1:0]    wdata_o,
    input  logic [DATA_W-1:0]    rdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
`ifdef MEM_TRAFFIC_GEN_ERR_CAPTURE_EN
    output logic                 err_vld_o,
    output logic [ADDR_W-1:0]    err_addr_o,
    output logic [DATA_W-1:0]    err_exp_o,
    output logic [DATA_W-1:0]    err_got_o,
`endif
    output logic                 pass_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q;
    logic [7:0]           run_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 chk_vld_q;
    logic [DATA_W-1:0]    exp_q;
    logic [DATA_W-1:0]    pattern;
    logic                 start_ok;
    logic                 mismatch;

    // Expected data for the address currently presented to the memory.
    assign pattern  = (SEED ^ DATA_W'(run_q)) + DATA_W'(addr_q);
    assign start_ok = start_i && (state_q == IDLE || state_q == DONE);
    assign mismatch = chk_vld_q && (rdata_i != exp_q);

    // NOTE: every signal assigned in an always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start_i) state_d = WRITE;
            WRITE:      if (addr_q == LAST_ADDR) state_d = READ;
            READ:       if (addr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:      state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            run_q     <= '0;
            err_q     <= '0;
            chk_vld_q <= 1'b0;
            exp_q     <= '0;
        end else begin
            state_q   <= state_d;
            chk_vld_q <= (state_q == READ);
            exp_q     <= pattern;

            if (mismatch && err_q != '1) begin
                err_q <= err_q + ERR_CNT_W'(1);
            end

            if (state_q == WRITE || state_q == READ) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            if (state_q == DRAIN) begin
                run_q <= run_q + 8'd1;
            end

            if (start_ok) begin
                addr_q <= '0;
                err_q  <= '0;
            end
        end
    end

`ifdef MEM_TRAFFIC_GEN_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] chk_addr_q;

    // Only the first mismatch of a run is kept; later ones leave the capture alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chk_addr_q <= '0;
            err_vld_o  <= 1'b0;
            err_addr_o <= '0;
            err_exp_o  <= '0;
            err_got_o  <= '0;
        end else begin
            chk_addr_q <= addr_q;
            if (start_ok) begin
                err_vld_o  <= 1'b0;
                err_addr_o <= '0;
                err_exp_o  <= '0;
                err_got_o  <= '0;
            end else if (mismatch && !err_vld_o) begin
                err_vld_o  <= 1'b1;
                err_addr_o <= chk_addr_q;
                err_exp_o  <= exp_q;
                err_got_o  <= rdata_i;
            end
        end
    end
`endif

    always_comb begin
        we_o      = (state_q == WRITE);
        addr_o    = (state_q == WRITE || state_q == READ) ? addr_q : '0;
        wdata_o   = (state_q == WRITE) ? pattern : '0;
        busy_o    = (state_q == WRITE || state_q == READ || state_q == DRAIN);
        done_o    = (state_q == DONE);
        err_cnt_o = err_q;
        pass_o    = (state_q == DONE) && (err_q == '0);
    end

endmodule
